// File: rtl/mdu_arbiter_pkg.sv
// Shared MDU definitions: arbiter state encoding and operator-field bit positions.
package mdu_arbiter_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [7:0] BUSY_CNT_MAX = 8'hFF;

  // Bit index of each operation class within the one-hot MDU operator field.
  typedef enum int {
    MUL_REQ = 0,
    DIV_REQ = 1,
    MT_REQ  = 2
  } mdu_op_bit_e;
endpackage

// File: rtl/mdu_arbiter_rr_arb2.sv
// Two-way round-robin grant; pointer flips away from the granted pipe on each taken grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_grant,
  output logic       o_any
);
  logic r_ptr;
  logic w_grant;

  // On a tie the pointer decides; otherwise the single requester wins.
  assign w_grant = (i_req == 2'b11) ? r_ptr : i_req[1];
  assign o_grant = w_grant;
  assign o_any   = |i_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (i_take && (|i_req)) begin
      r_ptr <= ~w_grant;
    end
  end
endmodule

// File: rtl/mdu_arbiter.sv
// Shares one MDU between two pipes: registered round-robin grant, issue, busy wait with watchdog.
module mdu_arbiter
  import mdu_arbiter_pkg::*;
#(
  parameter int OP_W     = 10,
  parameter int WD_LIMIT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [OP_W-1:0] req0_op,
  input  logic [63:0]     req0_opnd,
  input  logic            req0_cancel,
  output logic            req0_ready,
  output logic            req0_done,
  input  logic            req1_valid,
  input  logic [OP_W-1:0] req1_op,
  input  logic [63:0]     req1_opnd,
  input  logic            req1_cancel,
  output logic            req1_ready,
  output logic            req1_done,
  output logic            mdu_req,
  output logic            mdu_cancel,
  output logic [OP_W-1:0] mdu_op,
  output logic [63:0]     mdu_opnd,
  input  logic            mdu_oprand_ok,
  input  logic            mdu_data_ok,
  input  logic            mdu_is_mt,
  output logic            owner,
  output logic            wd_flag
);
  logic [1:0] r_state;
  logic       r_owner;
  logic [7:0] r_busy_cnt;

  logic [1:0] w_elig;
  logic       w_grant;
  logic       w_any;
  logic       w_idle;
  logic       w_issue;
  logic       w_busy;
  logic       w_own_cancel;
  logic       w_done;

  assign w_idle  = (r_state == S_IDLE);
  assign w_issue = (r_state == S_ISSUE);
  assign w_busy  = (r_state == S_BUSY);

  // A pipe being flushed this cycle is not eligible for a grant.
  assign w_elig       = {req1_valid & ~req1_cancel, req0_valid & ~req0_cancel};
  assign w_own_cancel = r_owner ? req1_cancel : req0_cancel;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_elig),
    .i_take  (w_idle),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_busy_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ISSUE;
            r_owner <= w_grant;
          end
        end
        S_ISSUE: begin
          if (w_own_cancel) begin
            r_state <= S_IDLE;
          end else if (mdu_oprand_ok) begin
            if (mdu_is_mt) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_BUSY;
              r_busy_cnt <= 8'd0;
            end
          end
        end
        S_BUSY: begin
          if (w_own_cancel || mdu_data_ok) begin
            r_state <= S_IDLE;
          end
          if (r_busy_cnt != BUSY_CNT_MAX) begin
            r_busy_cnt <= r_busy_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so nothing leaks out while reset is held.
  assign w_done = rst && !w_own_cancel &&
                  ((w_issue && mdu_oprand_ok && mdu_is_mt) || (w_busy && mdu_data_ok));

  assign mdu_req    = rst && w_issue;
  assign mdu_cancel = rst && (w_issue || w_busy) && w_own_cancel;
  assign req0_ready = rst && w_issue && mdu_oprand_ok && !r_owner;
  assign req1_ready = rst && w_issue && mdu_oprand_ok && r_owner;
  assign req0_done  = w_done && !r_owner;
  assign req1_done  = w_done && r_owner;
  assign owner      = rst && r_owner;
  assign wd_flag    = rst && w_busy && (int'(r_busy_cnt) >= WD_LIMIT);
  assign mdu_op     = (rst && w_issue) ? (r_owner ? req1_op : req0_op) : '0;
  assign mdu_opnd   = (rst && w_issue) ? (r_owner ? req1_opnd : req0_opnd) : '0;
endmodule

// File: tb/tb_mdu_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against a reference model.
module tb_mdu_arbiter;
  import mdu_arbiter_pkg::*;
  localparam int OPW = 10;
  localparam int WD  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]     v, c;
  logic [OPW-1:0] op [2];
  logic [63:0]    od [2];
  logic           oprand_ok, data_ok, is_mt;
  logic           r0, r1, d0, d1, mdu_req, mdu_cancel, own, wd_flag;
  logic [OPW-1:0] mdu_op;
  logic [63:0]    mdu_opnd;

  mdu_arbiter #(.OP_W(OPW), .WD_LIMIT(WD)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_op(op[0]), .req0_opnd(od[0]), .req0_cancel(c[0]),
    .req0_ready(r0), .req0_done(d0),
    .req1_valid(v[1]), .req1_op(op[1]), .req1_opnd(od[1]), .req1_cancel(c[1]),
    .req1_ready(r1), .req1_done(d1),
    .mdu_req(mdu_req), .mdu_cancel(mdu_cancel), .mdu_op(mdu_op), .mdu_opnd(mdu_opnd),
    .mdu_oprand_ok(oprand_ok), .mdu_data_ok(data_ok), .mdu_is_mt(is_mt),
    .owner(own), .wd_flag(wd_flag)
  );

  // Reference model: phase 0 = waiting, 1 = operands offered, 2 = waiting for result.
  int   m_ph   = 0;
  bit   m_own  = 1'b0;
  bit   m_ptr  = 1'b0;
  int   m_busy = 0;
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  logic [7:0] s_stat;   // {req, cancel, r1, r0, d1, d0, owner, wd}
  logic [1:0] last_rdy = 2'b00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    logic           cx, dn;
    logic [7:0]     es;
    logic [1:0]     e;
    logic [OPW-1:0] eop;
    logic [63:0]    eod;
    int             bsat;
    @(negedge clk);
    cx   = c[m_own];
    dn   = rst && !cx && ((m_ph == 1 && oprand_ok && is_mt) || (m_ph == 2 && data_ok));
    bsat = (m_busy > 255) ? 255 : m_busy;
    es[7] = rst && m_ph == 1;
    es[6] = rst && m_ph != 0 && cx;
    es[5] = rst && m_ph == 1 && m_own && oprand_ok;
    es[4] = rst && m_ph == 1 && !m_own && oprand_ok;
    es[3] = dn && m_own;
    es[2] = dn && !m_own;
    es[1] = rst && m_own;
    es[0] = rst && m_ph == 2 && bsat >= WD;
    eop = (rst && m_ph == 1) ? op[m_own] : '0;
    eod = (rst && m_ph == 1) ? od[m_own] : '0;
    s_stat = {mdu_req, mdu_cancel, r1, r0, d1, d0, own, wd_flag};
    chk("status", 64'(s_stat), 64'(es));
    chk("mdu_op", 64'(mdu_op), 64'(eop));
    chk("mdu_opnd", mdu_opnd, eod);
    last_rdy = {r1, r0};
    @(posedge clk);
    if (!rst) begin
      m_ph = 0; m_own = 1'b0; m_ptr = 1'b0; m_busy = 0;
    end else begin
      case (m_ph)
        0: begin
          e = v & ~c;
          if (e != 2'b00) begin
            m_own = (e == 2'b11) ? m_ptr : e[1];
            m_ptr = !m_own;
            m_ph  = 1;
          end
        end
        1: begin
          if (cx) m_ph = 0;
          else if (oprand_ok) begin
            if (is_mt) m_ph = 0;
            else begin m_ph = 2; m_busy = 0; end
          end
        end
        default: begin
          if (cx || data_ok) m_ph = 0;
          else m_busy++;
        end
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic quiet();
    v = 2'b00; c = 2'b00; oprand_ok = 1'b0; data_ok = 1'b0; is_mt = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  int t_d0;

  initial begin
    quiet();
    op[0] = '0; op[1] = '0; od[0] = '0; od[1] = '0;
    do_reset();

    // Single DIV from pipe 0.
    v[0] = 1'b1; op[0] = OPW'(1 << DIV_REQ); od[0] = {32'h2, 32'h7};
    for (int k = 0; k <= 40; k++) begin
      oprand_ok = (k == 3);
      data_ok   = (k == 36);
      if (k == 4) v[0] = 1'b0;
      step();
      if (k == 3)  chk("div_ready_c3", 64'(s_stat[4]), 64'd1);
      if (k == 36) chk("div_done_c36", 64'(s_stat[2]), 64'd1);
      if (k == 2)  chk("div_owner", 64'(s_stat[1]), 64'd0);
    end

    // Tie between the pipes, then a second tie after the pointer has cycled.
    do_reset();
    t_d0 = -100;
    op[0] = OPW'(1 << MUL_REQ); op[1] = OPW'(1 << MUL_REQ);
    od[0] = 64'h0000_0003_0000_0005; od[1] = 64'h0000_0011_0000_0013;
    for (int k = 0; k < 30; k++) begin
      for (int n = 0; n < 2; n++) if (v[n] && last_rdy[n]) v[n] = 1'b0;
      if (k == 0 || k == 20) v = 2'b11;
      oprand_ok = (m_ph == 1);
      data_ok   = (m_ph == 2 && m_busy == 2);
      step();
      if (k == 1) chk("tie_first_owner", 64'({s_stat[7], s_stat[1]}), 64'd2);
      if (s_stat[2] && t_d0 < 0) t_d0 = k;
      if (k == t_d0 + 2) chk("tie_second_grant", 64'({s_stat[7], s_stat[1]}), 64'd3);
      if (k == 21) chk("tie_rr_back", 64'({s_stat[7], s_stat[1]}), 64'd2);
    end

    // MTHI from pipe 1: ready and done together.
    do_reset();
    v[1] = 1'b1; op[1] = OPW'(1 << MT_REQ); od[1] = 64'h1234_5678_9abc_def0;
    for (int k = 0; k < 7; k++) begin
      oprand_ok = (k == 2);
      is_mt     = (k == 2);
      if (k == 3) v[1] = 1'b0;
      step();
      if (k == 2) chk("mt_ready_done", 64'({s_stat[5], s_stat[3], s_stat[1]}), 64'd7);
    end

    // Owner cancel at BUSY cycle 5; a late data_ok must be ignored.
    do_reset();
    v[0] = 1'b1; op[0] = OPW'(1 << DIV_REQ); od[0] = 64'hdead_beef_0bad_f00d;
    for (int k = 0; k < 15; k++) begin
      oprand_ok = (k == 2);
      if (k == 3) v[0] = 1'b0;
      c[0]    = (k == 8);
      data_ok = (k == 12);
      step();
      if (k == 8)  chk("cancel_busy", 64'({s_stat[6], s_stat[2]}), 64'd2);
      if (k == 12) chk("late_data_ignored", 64'(s_stat[2]), 64'd0);
    end

    // data_ok and owner cancel in the same cycle: cancel wins.
    do_reset();
    v[1] = 1'b1; op[1] = OPW'(1 << MUL_REQ); od[1] = 64'h5;
    for (int k = 0; k < 8; k++) begin
      oprand_ok = (k == 2);
      if (k == 3) v[1] = 1'b0;
      c[1]    = (k == 5);
      data_ok = (k == 5);
      step();
      if (k == 5) chk("cancel_beats_data", 64'({s_stat[6], s_stat[3]}), 64'd2);
    end

    // Watchdog: result withheld 70 BUSY cycles.
    do_reset();
    v[0] = 1'b1; op[0] = OPW'(1 << DIV_REQ); od[0] = 64'h9;
    for (int k = 0; k < 76; k++) begin
      oprand_ok = (k == 2);
      if (k == 3) v[0] = 1'b0;
      data_ok = (k == 73);
      step();
      if (k == 66) chk("wd_busy63", 64'(s_stat[0]), 64'd0);
      if (k == 67) chk("wd_busy64", 64'(s_stat[0]), 64'd1);
      if (k == 73) chk("wd_late_done", 64'(s_stat[2]), 64'd1);
    end

    // Reset asserted mid-BUSY alongside data_ok.
    do_reset();
    v[0] = 1'b1; op[0] = OPW'(1 << DIV_REQ); od[0] = 64'h77;
    for (int k = 0; k < 10; k++) begin
      oprand_ok = (k == 2);
      if (k == 3) v[0] = 1'b0;
      rst     = (k != 6);
      data_ok = (k == 6);
      step();
      if (k == 6) chk("rst_no_done", 64'(s_stat), 64'd0);
      if (k == 7) chk("rst_after", 64'(s_stat), 64'd0);
    end

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (v[n] && (last_rdy[n] || c[n])) v[n] = 1'b0;
        else if (!v[n] && $urandom_range(0, 3) == 0) begin
          v[n]  = 1'b1;
          op[n] = OPW'($urandom);
          od[n] = {$urandom, $urandom};
        end
        c[n] = ($urandom_range(0, 19) == 0);
      end
      oprand_ok = ($urandom_range(0, 2) == 0);
      data_ok   = ($urandom_range(0, 4) == 0);
      is_mt     = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
